// File: rtl/mem_access_if.sv
// mem_access_if: request/store/load handshakes plus main-memory bus for mem_access_master.
// master: the access engine; drives req_ready, wdata_ready, rsp_*, done, err, busy, mem_addr,
//         mem_data_in, mem_write_enable; samples req_*, wdata_valid, wdata, rsp_ready, mem_data_out.
// slave:  the CPU control unit plus memory side of the same signals.
interface mem_access_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;
    logic              done;
    logic              err;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_write_enable;
    logic [DATA_W-1:0] mem_data_out;
    modport master (
        input  req_valid, req_write, req_addr, req_len, wdata_valid, wdata, rsp_ready, mem_data_out,
        output req_ready, wdata_ready, rsp_valid, rsp_data, rsp_last, done, err, busy,
               mem_addr, mem_data_in, mem_write_enable
    );
    modport slave (
        output req_valid, req_write, req_addr, req_len, wdata_valid, wdata, rsp_ready, mem_data_out,
        input  req_ready, wdata_ready, rsp_valid, rsp_data, rsp_last, done, err, busy,
               mem_addr, mem_data_in, mem_write_enable
    );
endinterface

// File: rtl/mem_access_master.sv
// mem_access_master: burst load/store initiator for the 1-cycle registered-read main memory.
// Ports: clk (rising-edge clock), reset (synchronous, active-low), bus (mem_access_if.master:
// request, store-beat and load-response handshakes, done/err/busy status, memory address/data/strobe).
module mem_access_master #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 16384,
    parameter int LEN_W     = 8
) (
    input logic          clk,
    input logic          reset,
    mem_access_if.master bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] RSP   = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] ERR   = 3'd4;
    localparam logic [ADDR_W:0]   DEPTH     = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] next_addr;
    logic [LEN_W-1:0]  remaining;
    logic [DATA_W-1:0] wdata_hold;
    logic              done_q;
    logic              last;
    logic              beat;
    logic              rsp_take;
    logic              bad_req;

    assign next_addr = (cur_addr == LAST_ADDR) ? '0 : cur_addr + ADDR_W'(1);
    assign last      = remaining == LEN_W'(1);
    assign beat      = state == WRITE && bus.wdata_valid;
    assign rsp_take  = state == RSP && bus.rsp_ready;
    assign bad_req   = {1'b0, bus.req_addr} >= DEPTH || bus.req_len == '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cur_addr   <= '0;
            remaining  <= '0;
            wdata_hold <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (beat || rsp_take) && last;
            case (state)
                IDLE: if (bus.req_valid) begin
                    cur_addr  <= bus.req_addr;
                    remaining <= bus.req_len;
                    state     <= bad_req ? ERR : bus.req_write ? WRITE : READ;
                end
                READ: state <= RSP;
                // The final word leaves cur_addr in place; only non-final words advance.
                RSP: if (bus.rsp_ready) begin
                    remaining <= remaining - LEN_W'(1);
                    cur_addr  <= last ? cur_addr : next_addr;
                    state     <= last ? IDLE : READ;
                end
                WRITE: if (bus.wdata_valid) begin
                    wdata_hold <= bus.wdata;
                    remaining  <= remaining - LEN_W'(1);
                    cur_addr   <= next_addr;
                    state      <= last ? IDLE : WRITE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Every output is forced to its reset value while reset is low, so no write escapes in that cycle.
    assign bus.req_ready        = reset && state == IDLE;
    assign bus.busy             = reset && state != IDLE;
    assign bus.wdata_ready      = reset && state == WRITE;
    assign bus.mem_write_enable = reset && beat;
    assign bus.mem_addr         = reset ? cur_addr : '0;
    assign bus.mem_data_in      = !reset ? '0 : state == WRITE ? bus.wdata : wdata_hold;
    assign bus.rsp_valid        = reset && state == RSP;
    // Memory re-reads the held cur_addr, so the pass-through stays stable under backpressure.
    assign bus.rsp_data         = (reset && state == RSP) ? bus.mem_data_out : '0;
    assign bus.rsp_last         = reset && state == RSP && last;
    assign bus.done             = reset && done_q;
    assign bus.err              = reset && state == ERR;
endmodule

// File: tb/tb_mem_access_master.sv
// tb_mem_access_master: directed bursts against a transaction-level memory model with per-cycle checking.
module tb_mem_access_master;
    localparam int DEPTH = 16384;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_access_if bus ();
    mem_access_master dut (.clk(clk), .reset(reset), .bus(bus));

    logic [15:0] mem [DEPTH];
    logic [15:0] ref_mem [DEPTH];
    logic [31:0] exp_w [$];
    logic [16:0] exp_r [$];
    int n_checks = 0, n_fail = 0;
    int done_seen = 0, err_seen = 0, done_exp = 0, err_exp = 0;
    logic prev_hold = 1'b0;
    logic [15:0] prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %h expected nothing", name, act);
    endtask

    always @(posedge clk) begin
        if (bus.mem_write_enable && bus.mem_addr < 16'(DEPTH)) mem[bus.mem_addr[13:0]] <= bus.mem_data_in;
        bus.mem_data_out <= mem[bus.mem_addr[13:0]];
    end

    always @(negedge clk) begin
        logic [31:0] e;
        logic [16:0] r;
        if (bus.mem_write_enable) begin
            check("wr_addr_range", 32'(bus.mem_addr < 16'(DEPTH)), 1);
            if (exp_w.size() == 0) fail("unexpected_write", {bus.mem_addr, bus.mem_data_in});
            else begin
                e = exp_w.pop_front();
                check("wr_addr", 32'(bus.mem_addr), 32'(e[31:16]));
                check("wr_data", 32'(bus.mem_data_in), 32'(e[15:0]));
            end
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (exp_r.size() == 0) fail("unexpected_rsp", 32'(bus.rsp_data));
            else begin
                r = exp_r.pop_front();
                check("rsp_data", 32'(bus.rsp_data), 32'(r[15:0]));
                check("rsp_last", 32'(bus.rsp_last), 32'(r[16]));
            end
        end
        if (prev_hold) begin
            check("rsp_hold_valid", 32'(bus.rsp_valid), 1);
            check("rsp_hold_data", 32'(bus.rsp_data), 32'(prev_data));
        end
        prev_hold = bus.rsp_valid && !bus.rsp_ready;
        prev_data = bus.rsp_data;
        if (bus.done && bus.err) fail("done_and_err", 1);
        if (bus.done) done_seen++;
        if (bus.err) err_seen++;
    end

    function automatic logic [15:0] wrap(input logic [15:0] a, input int i);
        return 16'((int'(a) + i) % DEPTH);
    endfunction

    task automatic do_req(input logic w, input logic [15:0] a, input logic [7:0] l);
        int t = 0;
        while (!bus.req_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("req_ready_wait", 32'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_len   = l;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic store(input logic [15:0] a, input int l, input logic [15:0] d [4], input int gap);
        for (int i = 0; i < l; i++) begin
            exp_w.push_back({wrap(a, i), d[i]});
            ref_mem[wrap(a, i)] = d[i];
        end
        done_exp++;
        do_req(1'b1, a, 8'(l));
        for (int i = 0; i < l; i++) begin
            if (i == gap) begin
                bus.wdata_valid = 1'b0;
                bus.wdata = 16'hDEAD;
                @(posedge clk); #1;
                check("gap_wready", 32'(bus.wdata_ready), 1);
            end
            bus.wdata = d[i];
            bus.wdata_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.wdata_valid = 1'b0;
        check("store_done", 32'(bus.done), 1);
        check("store_idle", 32'(bus.busy), 0);
    endtask

    task automatic load(input logic [15:0] a, input int l, input int stall);
        int t = 0;
        for (int i = 0; i < l; i++) exp_r.push_back({i == l - 1, ref_mem[wrap(a, i)]});
        done_exp++;
        bus.rsp_ready = stall == 0;
        do_req(1'b0, a, 8'(l));
        if (stall > 0) begin
            while (!bus.rsp_valid && t < 10) begin
                @(posedge clk); #1;
                t++;
            end
            for (int s = 0; s < stall; s++) begin
                check("stall_valid", 32'(bus.rsp_valid), 1);
                check("stall_addr", 32'(bus.mem_addr), 32'(a));
                check("stall_data", 32'(bus.rsp_data), 32'(ref_mem[a]));
                @(posedge clk); #1;
            end
            bus.rsp_ready = 1'b1;
        end
        t = 0;
        while (!bus.done && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        check("load_done", 32'(bus.done), 1);
    endtask

    initial begin
        bus.req_valid = 0; bus.req_write = 0; bus.req_addr = 0; bus.req_len = 0;
        bus.wdata_valid = 0; bus.wdata = 0; bus.rsp_ready = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_rsp_last", 32'(bus.rsp_last), 0);
        check("rst_wdata_ready", 32'(bus.wdata_ready), 0);
        check("rst_mem_we", 32'(bus.mem_write_enable), 0);
        check("rst_mem_addr", 32'(bus.mem_addr), 0);
        check("rst_mem_din", 32'(bus.mem_data_in), 0);
        check("rst_rsp_data", 32'(bus.rsp_data), 0);
        reset = 1'b1;
        #1;
        check("idle_req_ready", 32'(bus.req_ready), 1);

        store(16'h0010, 3, '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h0000}, -1);
        check("mem_0010", 32'(mem[16'h0010]), 32'h0000AAAA);
        check("mem_0011", 32'(mem[16'h0011]), 32'h0000BBBB);
        check("mem_0012", 32'(mem[16'h0012]), 32'h0000CCCC);
        load(16'h0010, 3, 0);

        store(16'h0100, 1, '{16'h1234, 16'h0000, 16'h0000, 16'h0000}, -1);
        exp_r.push_back({1'b1, 16'h1234});
        done_exp++;
        bus.rsp_ready = 1'b1;
        do_req(1'b0, 16'h0100, 8'd1);
        check("lat_read_valid", 32'(bus.rsp_valid), 0);
        check("lat_read_busy", 32'(bus.busy), 1);
        @(posedge clk); #1;
        check("lat_rsp_valid", 32'(bus.rsp_valid), 1);
        check("lat_rsp_data", 32'(bus.rsp_data), 32'h00001234);
        check("lat_rsp_last", 32'(bus.rsp_last), 1);
        @(posedge clk); #1;
        check("lat_done", 32'(bus.done), 1);
        check("lat_req_ready", 32'(bus.req_ready), 1);

        load(16'h0010, 2, 5);

        store(16'h3FFF, 2, '{16'h1111, 16'h2222, 16'h0000, 16'h0000}, 1);
        check("mem_3fff", 32'(mem[16'h3FFF]), 32'h00001111);
        check("mem_0000", 32'(mem[16'h0000]), 32'h00002222);
        load(16'h3FFF, 2, 0);

        err_exp++;
        do_req(1'b0, 16'h4000, 8'd1);
        check("err_hi_addr", 32'(bus.err), 1);
        check("err_req_ready", 32'(bus.req_ready), 0);
        @(posedge clk); #1;
        check("err_pulse_end", 32'(bus.err), 0);
        check("err_back_idle", 32'(bus.req_ready), 1);
        err_exp++;
        do_req(1'b1, 16'h0000, 8'd0);
        check("err_len0", 32'(bus.err), 1);
        check("err_len0_wready", 32'(bus.wdata_ready), 0);
        @(posedge clk); #1;
        check("err_len0_end", 32'(bus.err), 0);
        check("err_len0_idle", 32'(bus.req_ready), 1);

        exp_w.push_back({16'h0020, 16'h5555});
        do_req(1'b1, 16'h0020, 8'd4);
        bus.wdata = 16'h5555;
        bus.wdata_valid = 1'b1;
        @(posedge clk); #1;
        bus.wdata = 16'h6666;
        reset = 1'b0;
        #1;
        check("rst_mid_no_we", 32'(bus.mem_write_enable), 0);
        check("rst_mid_wready", 32'(bus.wdata_ready), 0);
        @(posedge clk); #1;
        check("rst_mid_busy", 32'(bus.busy), 0);
        check("rst_mid_req_ready", 32'(bus.req_ready), 0);
        reset = 1'b1;
        bus.wdata_valid = 1'b0;
        #1;
        check("post_rst_busy", 32'(bus.busy), 0);
        check("post_rst_req_ready", 32'(bus.req_ready), 1);
        check("post_rst_addr", 32'(bus.mem_addr), 0);
        check("post_rst_din", 32'(bus.mem_data_in), 0);
        @(posedge clk); #1;
        check("post_rst_done", 32'(bus.done), 0);
        check("mem_0021", 32'(mem[16'h0021] === 16'h6666), 0);
        repeat (3) @(posedge clk);
        #1;

        check("done_count", 32'(done_seen), 32'(done_exp));
        check("err_count", 32'(err_seen), 32'(err_exp));
        check("writes_left", 32'(exp_w.size()), 0);
        check("reads_left", 32'(exp_r.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
